keypad_entry_sequencer: RTL and testbench

Sequences the 12-key priority encoder into complete PIN entries for the safe-lock FSM. Debounces encoder output, accepts one key per press/release cycle, and buffers up to DIGITS digits. Handles CLEAR (code 10, '*') and ENTER (code 11, '#'). Hands finished entries to the lock FSM over a valid/ready handshake.

---
 rtl/keypad_entry_sequencer_if.sv | 29 ++
 rtl/keypad_entry_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_keypad_entry_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_sequencer_if.sv
// Keypad sequencer bus: encoder input, entry handshake and status outputs.
// master = sequencer side, slave = encoder/lock side.
interface keypad_entry_sequencer_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned LEN_W  = $clog2(DIGITS + 1);
  localparam int unsigned CODE_W = 4 * DIGITS;

  logic [3:0]        key_code;
  logic              key_valid;
  logic              entry_ready;
  logic              entry_valid;
  logic [CODE_W-1:0] entry_code;
  logic [LEN_W-1:0]  entry_len;
  logic              key_strobe;
  logic              overflow;
  logic              busy;
  logic              timeout;

  modport master (
    input  key_code, key_valid, entry_ready,
    output entry_valid, entry_code, entry_len, key_strobe, overflow, busy, timeout
  );

  modport slave (
    output key_code, key_valid, entry_ready,
    input  entry_valid, entry_code, entry_len, key_strobe, overflow, busy, timeout
  );
endinterface

// File: rtl/keypad_entry_sequencer.sv
// Debounces 12-key encoder output into PIN entries and hands them to the lock FSM.
// Optional inter-key idle timeout is built only when KEYPAD_TIMEOUT_EN is defined.
module keypad_entry_sequencer #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned DEBOUNCE       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  keypad_entry_sequencer_if.master bus
);
  localparam int unsigned LEN_W   = $clog2(DIGITS + 1);
  localparam int unsigned CODE_W  = 4 * DIGITS;
  localparam int unsigned CNT_MAX = (DEBOUNCE > TIMEOUT_CYCLES) ? DEBOUNCE : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DB_LIMIT   = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);
  localparam logic [LEN_W-1:0] LEN_FULL   = LEN_W'(DIGITS);
  localparam logic [3:0]       KEY_CLEAR  = 4'd10;
  localparam logic [3:0]       KEY_ENTER  = 4'd11;
  localparam logic [3:0]       KEY_LIMIT  = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DB_PRESS,
    S_HELD,
    S_DB_RELEASE,
    S_SUBMIT
  } state_t;

  state_t            state;
  logic [3:0]        code_q;
  logic [CNT_W-1:0]  cnt;
  logic [CODE_W-1:0] buffer;
  logic [LEN_W-1:0]  entry_len;
  logic              entry_valid;
  logic              key_strobe;
  logic              overflow;
  logic              busy;
  logic              key_hit_c;

  // Codes 12-15 behave exactly like no key pressed.
  assign key_hit_c = bus.key_valid && (bus.key_code < KEY_LIMIT);

`ifdef KEYPAD_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] idle_cnt;
  logic             timeout;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      code_q      <= '0;
      cnt         <= '0;
      buffer      <= '0;
      entry_len   <= '0;
      entry_valid <= 1'b0;
      key_strobe  <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
      idle_cnt    <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      key_strobe <= 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
      timeout    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (key_hit_c) begin
            state  <= S_DB_PRESS;
            code_q <= bus.key_code;
            cnt    <= CNT_W'(1);
            busy   <= 1'b1;
`ifdef KEYPAD_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
`ifdef KEYPAD_TIMEOUT_EN
          // A partial entry left idle too long is discarded.
          else if (entry_len != '0) begin
            if (idle_cnt >= TO_LAST) begin
              buffer    <= '0;
              entry_len <= '0;
              overflow  <= 1'b0;
              timeout   <= 1'b1;
              idle_cnt  <= '0;
            end else begin
              idle_cnt <= idle_cnt + CNT_W'(1);
            end
          end
`endif
        end

        S_DB_PRESS: begin
          // The count already covers DEBOUNCE samples: accept regardless of this cycle's input.
          if (cnt >= DB_LIMIT) begin
            key_strobe <= 1'b1;
            state      <= S_HELD;
            if (code_q == KEY_CLEAR) begin
              buffer    <= '0;
              entry_len <= '0;
              overflow  <= 1'b0;
            end else if (code_q == KEY_ENTER) begin
              if (entry_len != '0) begin
                entry_valid <= 1'b1;
                state       <= S_SUBMIT;
              end
            end else if (entry_len < LEN_FULL) begin
              for (int i = 0; i < DIGITS; i++) begin
                if (entry_len == LEN_W'(i)) buffer[4*i +: 4] <= code_q;
              end
              entry_len <= entry_len + LEN_W'(1);
            end else begin
              overflow <= 1'b1;
            end
          end else if (!key_hit_c) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (bus.key_code != code_q) begin
            code_q <= bus.key_code;
            cnt    <= CNT_W'(1);
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_HELD: begin
          if (!key_hit_c) begin
            state <= S_DB_RELEASE;
            cnt   <= CNT_W'(1);
          end
        end

        S_DB_RELEASE: begin
          if (cnt >= DB_LIMIT) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (key_hit_c) begin
            state <= S_HELD;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_SUBMIT: begin
          // Entry is frozen until the lock FSM takes it.
          if (entry_valid && bus.entry_ready) begin
            entry_valid <= 1'b0;
            buffer      <= '0;
            entry_len   <= '0;
            overflow    <= 1'b0;
            state       <= S_HELD;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.entry_valid = entry_valid;
  assign bus.entry_code  = buffer;
  assign bus.entry_len   = entry_len;
  assign bus.key_strobe  = key_strobe;
  assign bus.overflow    = overflow;
  assign bus.busy        = busy;
`ifdef KEYPAD_TIMEOUT_EN
  assign bus.timeout     = timeout;
`else
  assign bus.timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_entry_sequencer.sv
// Randomized press/release stimulus against a key-event level model of PIN entry.
module tb_keypad_entry_sequencer;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned DB     = 4;
`ifdef KEYPAD_TIMEOUT_EN
  localparam int unsigned TO = 20;
`else
  localparam int unsigned TO = 1000000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_entry_sequencer_if #(.DIGITS(DIGITS)) bus ();

  keypad_entry_sequencer #(
    .DIGITS(DIGITS), .DEBOUNCE(DB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc = 0, strobes = 0, strobe_cyc = 0, tmo_seen = 0;
  logic strobe_ev = 1'b0;

  // Reference model: digits in entry order plus sticky overflow.
  logic [3:0] q[$];
  bit m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_code();
    logic [31:0] e;
    e = '0;
    foreach (q[i]) e[4*i +: 4] = q[i];
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.key_strobe === 1'b1) begin
      strobes++;
      strobe_cyc = cyc;
      strobe_ev  = bus.entry_valid;
    end
    if (bus.timeout === 1'b1) tmo_seen++;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_len"}, 32'(bus.entry_len), 32'(q.size()));
    check({tag, "_code"}, 32'(bus.entry_code), exp_code());
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(m_ovf));
    check({tag, "_ev"}, 32'(bus.entry_valid), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  // One press: optional bounce prefix, main hold, optional mid-hold code switch,
  // optional release glitch, then a full release.
  task automatic press(input logic [3:0] pre_code, input int pre_len, input logic [3:0] code,
                       input int hold, input int sw_code, input bit glitch, input int wait_n);
    int s0, st0, w;
    bit acc, sub;
    acc = (code < 4'd12) && (hold >= int'(DB));
    sub = acc && (code == 4'd11) && (q.size() > 0);
    bus.entry_ready = (code != 4'd11) ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.key_valid = 1'b1;
    for (int i = 0; i < pre_len; i++) begin
      bus.key_code = pre_code;
      tick();
    end
    bus.key_code = code;
    s0  = cyc;
    st0 = strobes;
    for (int i = 0; i < hold; i++) begin
      if (sw_code >= 0 && i == int'(DB)) bus.key_code = 4'(sw_code);
      tick();
    end
    if (sub) begin
      w = (wait_n < 0) ? int'($urandom_range(0, 10)) : wait_n;
      for (int i = 0; i < w; i++) begin
        bus.key_valid = 1'($urandom_range(0, 1));
        bus.key_code  = 4'($urandom_range(0, 15));
        tick();
        check("sub_ev", 32'(bus.entry_valid), 1);
        check("sub_code", 32'(bus.entry_code), exp_code());
        check("sub_len", 32'(bus.entry_len), 32'(q.size()));
      end
      bus.entry_ready = 1'b1;
      tick();
      bus.entry_ready = 1'b0;
      q.delete();
      m_ovf = 1'b0;
      check("hs_ev", 32'(bus.entry_valid), 0);
      check("hs_len", 32'(bus.entry_len), 0);
      check("hs_code", 32'(bus.entry_code), 0);
      check("hs_ovf", 32'(bus.overflow), 0);
    end
    if (glitch && acc) begin
      bus.key_valid = 1'b0;
      tick();
      tick();
      bus.key_valid = 1'b1;
      bus.key_code  = 4'($urandom_range(0, 9));
      repeat (3) tick();
    end
    bus.key_valid = 1'b0;
    repeat (DB + 2 + $urandom_range(0, 2)) tick();
    bus.entry_ready = 1'b0;
    check("strobe_n", 32'(strobes - st0), 32'(acc));
    if (acc) begin
      check("strobe_t", 32'(strobe_cyc - s0), DB + 1);
      check("strobe_ev", 32'(strobe_ev), 32'(sub));
      if (code < 4'd10) begin
        if (q.size() < DIGITS) q.push_back(code);
        else m_ovf = 1'b1;
      end else if (code == 4'd10) begin
        q.delete();
        m_ovf = 1'b0;
      end
    end
    check_idle_state("post");
  endtask

  initial begin
    int tmo_local;
    logic [3:0] c, p;
    int h;
    bus.key_code = '0;
    bus.key_valid = 1'b0;
    bus.entry_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_idle_state("reset");
    check("reset_strobe", 32'(bus.key_strobe), 0);
    check("reset_tmo", 32'(bus.timeout), 0);

    // Short press rejected, exact-DEBOUNCE press accepted.
    press(4'd0, 0, 4'd5, 3, -1, 1'b0, 0);
    press(4'd0, 0, 4'd5, 4, -1, 1'b0, 0);
    press(4'd0, 0, 4'd10, 5, -1, 1'b0, 0);

    // Fill, overflow, then submit with a 10-cycle stall.
    press(4'd0, 0, 4'd1, 5, -1, 1'b0, 0);
    press(4'd0, 0, 4'd2, 5, -1, 1'b0, 0);
    press(4'd0, 0, 4'd3, 5, -1, 1'b0, 0);
    press(4'd0, 0, 4'd4, 5, -1, 1'b0, 0);
    press(4'd0, 0, 4'd7, 5, -1, 1'b0, 0);
    check("ovf_set", 32'(bus.overflow), 1);
    check("full_code", 32'(bus.entry_code), 32'h4321);
    press(4'd0, 0, 4'd11, 6, -1, 1'b0, 10);

    // CLEAR then ENTER on an empty buffer.
    press(4'd0, 0, 4'd8, 5, -1, 1'b0, 0);
    press(4'd0, 0, 4'd9, 5, -1, 1'b0, 0);
    press(4'd0, 0, 4'd10, 5, -1, 1'b0, 0);
    press(4'd0, 0, 4'd11, 5, -1, 1'b0, 0);

    // Code switch while held and a release glitch yield one accept.
    press(4'd0, 0, 4'd3, 6, 6, 1'b1, 0);
    check("glitch_code", 32'(bus.entry_code), 32'h3);
    press(4'd2, 2, 4'd10, 5, -1, 1'b0, 0);

    // Reset mid-press drops everything immediately.
    press(4'd0, 0, 4'd1, 5, -1, 1'b0, 0);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd7;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    check_idle_state("arst");
    bus.key_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    h = strobes;
    repeat (DB + 2) tick();
    check("arst_nostrobe", 32'(strobes - h), 0);
    check_idle_state("arst_after");

    // Idle behaviour of a partial entry.
    press(4'd0, 0, 4'd2, 5, -1, 1'b0, 0);
`ifdef KEYPAD_TIMEOUT_EN
    tmo_local = tmo_seen;
    repeat (30) tick();
    q.delete();
    m_ovf = 1'b0;
    check("tmo_pulse", 32'(tmo_seen - tmo_local), 1);
    check_idle_state("tmo");
`else
    tmo_local = 0;
    repeat (1000) tick();
    check_idle_state("persist");
    press(4'd0, 0, 4'd10, 5, -1, 1'b0, 0);
`endif

    // Randomized press sequences.
    for (int n = 0; n < 250; n++) begin
`ifdef KEYPAD_TIMEOUT_EN
      c = 4'($urandom_range(0, 11));
`else
      c = 4'($urandom_range(0, 15));
`endif
      if (c >= 4'd12) h = int'($urandom_range(1, 3));
      else if (c == 4'd11 && q.size() > 0) h = int'($urandom_range(DB + 1, DB + 3));
      else h = int'($urandom_range(1, DB + 3));
      p = 4'($urandom_range(0, 9));
      if (p == c) p = 4'((p + 1) % 10);
      press(p, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DB - 1)) : 0, c, h,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1,
            1'($urandom_range(0, 3) == 0), -1);
    end

`ifdef KEYPAD_TIMEOUT_EN
    check("tmo_total", 32'(tmo_seen), 1);
`else
    check("tmo_total", 32'(tmo_seen), 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
